bus_interconnect_n: RTL

Parametrised, registered successor of the two-slave bus interconnect. It routes one master `bus_if` to `NUM_SLAVES` slave `bus_if` ports by address region. Behaviour added over the two-slave version:
- one outstanding transaction, with the request latched;
- decode-error and read-only-violation responses;
- a per-transaction slave timeout;
- status counters.

It sits between the bus master (CPU or transaction manager) and the peripheral slaves in the SoC-level bus fabric.

---
 rtl/bus_interconnect_n.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bus_interconnect_n.sv
// bus_interconnect_n
// Routes one upstream master bus to NUM_SLAVES downstream slave buses by
// address region. One transaction is outstanding at a time; the request is
// latched in IDLE and replayed to the selected slave while in FWD. The block
// answers decode/protection errors itself, times out a silent slave, and keeps
// a saturating count of error responses.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   master_valid/ready         upstream handshake (ready is a 1-cycle pulse)
//   master_wr_en/addr/wdata    upstream request
//   master_rdata/resp          upstream response (registered)
//   s_valid[i]/s_ready[i]      per-slave handshake
//   s_wr_en/s_addr/s_wdata     latched request fanned out to every slave
//   s_rdata[i]/s_resp[i]       per-slave response
//   busy                       state != IDLE
//   timeout_evt                one-cycle pulse in the ERR cycle of a timeout
//   err_count                  saturating count of RESP_ERROR responses
module bus_interconnect_n #(
    parameter int                    NUM_SLAVES     = 2,
    parameter int                    ADDR_W         = 8,
    parameter int                    DATA_W         = 8,
    parameter int                    REGION_SIZE    = 'h40,
    parameter logic [NUM_SLAVES-1:0] RO_MASK        = '0,
    parameter int                    TIMEOUT_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 master_valid,
    output logic                                 master_ready,
    input  logic                                 master_wr_en,
    input  logic [ADDR_W-1:0]                    master_addr,
    input  logic [DATA_W-1:0]                    master_wdata,
    output logic [DATA_W-1:0]                    master_rdata,
    output logic [1:0]                           master_resp,
    output logic [NUM_SLAVES-1:0]                s_valid,
    input  logic [NUM_SLAVES-1:0]                s_ready,
    output logic [NUM_SLAVES-1:0]                s_wr_en,
    output logic [NUM_SLAVES-1:0][ADDR_W-1:0]    s_addr,
    output logic [NUM_SLAVES-1:0][DATA_W-1:0]    s_wdata,
    input  logic [NUM_SLAVES-1:0][DATA_W-1:0]    s_rdata,
    input  logic [NUM_SLAVES-1:0][1:0]           s_resp,
    output logic                                 busy,
    output logic                                 timeout_evt,
    output logic [15:0]                          err_count
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b10;

    localparam int IDX_W        = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TCNT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int REGION_SHIFT = $clog2(REGION_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_ERR  = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_en_q, wr_en_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;
    logic                timeout_evt_q, timeout_evt_d;
    logic [15:0]         err_count_q, err_count_d;

    // Region decode of the live request (only used in IDLE).
    logic [ADDR_W-1:0]   idx_full;
    logic [IDX_W-1:0]    idx_sel;
    logic                decode_err;
    logic                prot_err;

    always_comb begin
        idx_full   = master_addr >> REGION_SHIFT;
        idx_sel    = idx_full[IDX_W-1:0];
        decode_err = (idx_full >= ADDR_W'(NUM_SLAVES));
        // Protection is only meaningful once the index is known to be in range.
        prot_err   = !decode_err && master_wr_en && RO_MASK[idx_sel];
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wr_en_d       = wr_en_q;
        idx_d         = idx_q;
        tcnt_d        = tcnt_q;
        rdata_d       = rdata_q;
        resp_d        = resp_q;
        timeout_evt_d = 1'b0;
        err_count_d   = err_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (master_valid) begin
                    addr_d  = master_addr;
                    wdata_d = master_wdata;
                    wr_en_d = master_wr_en;
                    idx_d   = idx_sel;
                    tcnt_d  = '0;
                    state_d = (decode_err || prot_err) ? ST_ERR : ST_FWD;
                end
            end
            ST_FWD: begin
                // Ready wins over the timeout, so a slave answering in the
                // final allowed cycle still gets its response through.
                if (s_ready[idx_q]) begin
                    rdata_d = s_rdata[idx_q];
                    resp_d  = s_resp[idx_q];
                    state_d = ST_RSP;
                end else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_evt_d = 1'b1;
                    state_d       = ST_ERR;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                rdata_d = '0;
                resp_d  = RESP_ERROR;
                state_d = ST_RSP;
            end
            ST_RSP: begin
                if (resp_q == RESP_ERROR && err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wr_en_q       <= 1'b0;
            idx_q         <= '0;
            tcnt_q        <= '0;
            rdata_q       <= '0;
            resp_q        <= RESP_OKAY;
            timeout_evt_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wr_en_q       <= wr_en_d;
            idx_q         <= idx_d;
            tcnt_q        <= tcnt_d;
            rdata_q       <= rdata_d;
            resp_q        <= resp_d;
            timeout_evt_q <= timeout_evt_d;
            err_count_q   <= err_count_d;
        end
    end

    // All outputs are decoded from registers only; nothing combinational
    // passes from a slave input to the master or vice versa.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_fanout
            assign s_valid[gi] = (state_q == ST_FWD) && (idx_q == IDX_W'(gi));
            assign s_wr_en[gi] = wr_en_q;
            assign s_addr[gi]  = addr_q;
            assign s_wdata[gi] = wdata_q;
        end
    endgenerate

    assign master_ready = (state_q == ST_RSP);
    assign master_rdata = rdata_q;
    assign master_resp  = resp_q;
    assign busy         = (state_q != ST_IDLE);
    assign timeout_evt  = timeout_evt_q;
    assign err_count    = err_count_q;

endmodule
